// File: rtl/hash_target_check.sv
// hash_target_check: streams a candidate hash and a difficulty target one
// word at a time, most-significant word first, and reports whether
// hash < target (meets) or hash == target (equal) as unsigned numbers.
// The first unequal word pair decides the result; later words are drained
// without affecting it.
//
// Optional feature: define HTC_HIT_COUNT_EN to add a saturating 16-bit
// counter of completed compares that met the target (output hit_count).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; last result held on meets/equal
// S_COMPARE | accepting word pairs, in_ready high, stalls on in_valid=0
// S_DONE    | one-cycle done strobe, then back to S_IDLE

module hash_target_check #(
    parameter int WORDS  = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] hash_word,
    input  logic [WORD_W-1:0] target_word,
    output logic              busy,
    output logic              done,
    output logic              meets,
`ifdef HTC_HIT_COUNT_EN
    output logic              equal,
    output logic [15:0]       hit_count
`else
    output logic              equal
`endif
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             meets_q, meets_d;
    logic             equal_q, equal_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef HTC_HIT_COUNT_EN
    logic [15:0]      hit_count_q, hit_count_d;
`endif

    logic words_differ;
    logic hash_lt;

    assign words_differ = (hash_word != target_word);
    assign hash_lt      = (hash_word < target_word);

    // Next-state, counter and result logic; status outputs follow the next state
    // so they are registered yet aligned with the state they describe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        meets_d   = meets_q;
        equal_d   = equal_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_COMPARE;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    meets_d   = 1'b0;
                    equal_d   = 1'b0;
                end
            end
            S_COMPARE: begin
                if (in_valid) begin
                    if (!decided_q && words_differ) begin
                        decided_d = 1'b1;
                        meets_d   = hash_lt;
                        equal_d   = 1'b0;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                        // Every word matched: the numbers are identical.
                        if (!decided_q && !words_differ) begin
                            equal_d = 1'b1;
                            meets_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_COMPARE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

`ifdef HTC_HIT_COUNT_EN
    // Count completed compares that met the target, saturating at all-ones.
    always_comb begin
        hit_count_d = hit_count_q;
        if ((state_d == S_DONE) && (state_q == S_COMPARE) && meets_d &&
            (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
    end
`endif

    // Single state register for the FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            decided_q   <= 1'b0;
            meets_q     <= 1'b0;
            equal_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef HTC_HIT_COUNT_EN
            hit_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            decided_q   <= decided_d;
            meets_q     <= meets_d;
            equal_q     <= equal_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef HTC_HIT_COUNT_EN
            hit_count_q <= hit_count_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign meets    = meets_q;
    assign equal    = equal_q;
`ifdef HTC_HIT_COUNT_EN
    assign hit_count = hit_count_q;
`endif

endmodule

// File: doc/hash_target_check.md
HASH_TARGET_CHECK -- requirements
Module: hash_target_check

Interface
REQ-001 Parameter WORDS, default 8, SHALL set the number of 32-bit words per compare (8 words = 256-bit hash).
REQ-002 Parameter WORD_W, default 32, SHALL set the word width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new compare; sampled only in IDLE.
REQ-006 in_valid  input  1  SHALL qualify hash_word/target_word.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-008 hash_word  input  WORD_W  SHALL carry a candidate hash word, most-significant word first.
REQ-009 target_word  input  WORD_W  SHALL carry a difficulty target word, most-significant word first.
REQ-010 busy  output  1  SHALL be high while not IDLE.
REQ-011 done  output  1  SHALL be a one-cycle result strobe.
REQ-012 meets  output  1  SHALL be high when hash < target (unsigned); valid while done=1, held until next start.
REQ-013 equal  output  1  SHALL be high when hash == target; same validity as meets.

Function
REQ-014 Block SHALL implement states IDLE, COMPARE, DONE.
REQ-015 IDLE -> COMPARE on start=1; word counter and decided flag SHALL clear on that edge.
REQ-016 in_ready SHALL equal 1 exactly in COMPARE; a word transfers on in_valid & in_ready.
REQ-017 Per transfer, with decided=0: words unequal -> decided=1, meets=(hash_word<target_word), equal=0; words equal -> no change.
REQ-018 Once decided=1, later words SHALL still be accepted (drained) but SHALL NOT alter meets/equal.
REQ-019 On the WORDS-th transfer, state SHALL go COMPARE -> DONE; if decided=0, equal=1 and meets=0.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE; result latency = 1 cycle after the last accepted word.
REQ-021 in_valid=0 in COMPARE SHALL stall without state change; no timeout.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 Word counter SHALL be $clog2(WORDS) bits minimum (1 bit when WORDS=1); it SHALL NOT wrap within a compare.
REQ-024 Comparison SHALL be unsigned, word-by-word, MSB word first; hash==target SHALL NOT count as meets.

Reset
REQ-025 rst=1 SHALL force IDLE, counter=0, decided=0, meets=0, equal=0, done=0, in_ready=0, busy=0 on the next edge.
REQ-026 rst mid-compare SHALL abort with no done pulse; partial result discarded.
REQ-027 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-028 Macro HTC_HIT_COUNT_EN defined SHALL add output hit_count[15:0], incremented on each done with meets=1, saturating at 16'hFFFF, cleared by rst.
REQ-029 Macro HTC_HIT_COUNT_EN undefined SHALL omit hit_count port and logic; all other behaviour identical.

Verification
REQ-030 WORDS=8, word0 hash=0x0000_0000, target=0x0000_FFFF, remaining words arbitrary -> done one cycle after 8th transfer, meets=1, equal=0.
REQ-031 All 8 words equal (0xDEAD_BEEF both) -> done, meets=0, equal=1.
REQ-032 Words 0-6 equal, word7 hash=0x10, target=0x0F -> meets=0, equal=0; in_valid toggled 1/0 each cycle -> result unchanged, done after 8th transfer.
REQ-033 rst asserted after 3 transfers -> no done; new start with word0 hash<target -> meets=1.
REQ-034 start pulsed during COMPARE -> ignored, exactly one done per compare.
REQ-035 With HTC_HIT_COUNT_EN: 3 meeting compares + 1 failing -> hit_count=3; rst -> hit_count=0.
